// File: rtl/obi_gnt_stall.sv
// OBI request-side grant perturbation: withholds gnt for a none/fixed/LFSR-random delay per request.
// Optional define OBI_GNT_STALL_OUTSTANDING_EN gates gnt on a free outstanding-transaction slot.
module obi_gnt_stall #(
   parameter logic [31:0] LFSR_SEED       = 32'hACE1_2468,
   parameter int unsigned DELAY_WL        = 4,
   parameter int unsigned MAX_OUTSTANDING = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] wdata_i,
   output logic        gnt_o,
   output logic        req_o,
   output logic        we_o,
   output logic [31:0] addr_o,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   input  logic        rvalid_i,
   input  logic        en_stall_i,
   input  logic [31:0] stall_mode_i,
   input  logic [31:0] max_stall_i,
   input  logic [31:0] gnt_stall_i,
   output logic        protocol_err_o
);

   localparam int unsigned MAX_D = (1 << DELAY_WL) - 1;
   localparam int unsigned OW    = $clog2(MAX_OUTSTANDING) + 1;
   localparam logic [31:0] SEED  = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
   localparam logic [31:0] TAPS  = 32'h8020_0003;

   typedef enum logic {
      S_IDLE,
      S_STALL
   } state_e;

   state_e              state_q;
   logic [DELAY_WL-1:0] cnt_q;
   logic [31:0]         lfsr_q;
   logic [31:0]         lfsr_d;
   logic [OW-1:0]       out_q;
   logic [OW-1:0]       out_d;
   logic                err_q;

   logic [DELAY_WL-1:0] std_c;
   logic [DELAY_WL-1:0] rmax_c;
   logic [DELAY_WL-1:0] rnd_c;
   logic [DELAY_WL-1:0] delay_c;
   logic                slot_ok_c;
   logic                gnt_c;
   logic                req_c;

   // Per-request delay candidate, only consumed when a request is seen in IDLE
   always_comb begin
      std_c   = (gnt_stall_i > 32'(MAX_D)) ? DELAY_WL'(MAX_D) : DELAY_WL'(gnt_stall_i);
      rmax_c  = (max_stall_i > 32'(MAX_D)) ? DELAY_WL'(MAX_D) : DELAY_WL'(max_stall_i);
      rnd_c   = DELAY_WL'(lfsr_q % (32'(rmax_c) + 32'd1));
      delay_c = '0;
      if (en_stall_i) begin
         case (stall_mode_i)
            32'd1:   delay_c = std_c;
            32'd2:   delay_c = rnd_c;
            default: delay_c = '0;
         endcase
      end
   end

`ifdef OBI_GNT_STALL_OUTSTANDING_EN
   assign slot_ok_c = (out_q < OW'(MAX_OUTSTANDING)) | rvalid_i;
`else
   assign slot_ok_c = 1'b1;
`endif

   // Grant is combinational so a zero-delay request is accepted in its first cycle
   always_comb begin
      gnt_c = 1'b0;
      if (!rst_i && req_i && slot_ok_c) begin
         if (state_q == S_IDLE) begin
            gnt_c = (delay_c == '0);
         end else begin
            gnt_c = (cnt_q == '0);
         end
      end
   end

   assign req_c = req_i & gnt_c;

   always_comb begin
      lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? TAPS : 32'h0);
      out_d  = out_q;
      if (req_c && !rvalid_i) begin
         if (out_q < OW'(MAX_OUTSTANDING)) out_d = out_q + 1'b1;
      end else if (!req_c && rvalid_i) begin
         if (out_q != '0) out_d = out_q - 1'b1;
      end
   end

   // A zero-delay request blocked on a slot parks in STALL with cnt 0 so its delay is not re-drawn
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         lfsr_q  <= SEED;
         out_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         lfsr_q <= lfsr_d;
         out_q  <= out_d;
         err_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (req_i && !gnt_c) begin
                  state_q <= S_STALL;
                  cnt_q   <= (delay_c == '0) ? '0 : delay_c - 1'b1;
               end
            end
            S_STALL: begin
               if (!req_i) begin
                  state_q <= S_IDLE;
                  cnt_q   <= '0;
                  err_q   <= 1'b1;
               end else if (gnt_c) begin
                  state_q <= S_IDLE;
               end else if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign gnt_o          = gnt_c;
   assign req_o          = req_c;
   assign we_o           = we_i;
   assign addr_o         = addr_i;
   assign be_o           = be_i;
   assign wdata_o        = wdata_i;
   assign protocol_err_o = err_q;

endmodule
